// File: rtl/pip_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pip_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] ZERO_REG = 5'd0;

  // Pipeline register controls, MSB first in this order.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL   = ctrl_t'(8'b1111_1000);
  localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b1111_1110);
  localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(8'b0011_1010);
  localparam ctrl_t CTRL_FREEZE   = ctrl_t'(8'b0000_1001);
  localparam ctrl_t CTRL_ERROR    = ctrl_t'(8'b0000_0001);

endpackage

// File: rtl/pip_fwd_unit.sv
// Forwarding select for one EX operand; MEM result wins over WB.
module pip_fwd_unit
  import pip_ctrl_pkg::*;
(
  input  logic [4:0] src_ad,
  input  logic [4:0] mem_rd_ad,
  input  logic       mem_rdEn,
  input  logic [4:0] wb_rd_ad,
  input  logic       wb_rdEn,
  output logic [1:0] fwd_sel
);

  // Priority compare against the younger (MEM) then older (WB) producer.
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_rdEn && (mem_rd_ad != ZERO_REG) && (mem_rd_ad == src_ad))
      fwd_sel = FWD_MEM;
    else if (wb_rdEn && (wb_rd_ad != ZERO_REG) && (wb_rd_ad == src_ad))
      fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, memory waits and forwarding.
module pip_hazard_ctrl
  import pip_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_ad,
  input  logic [4:0]       id_rs2_ad,
  input  logic [4:0]       ex_rs1_ad,
  input  logic [4:0]       ex_rs2_ad,
  input  logic [4:0]       ex_rd_ad,
  input  logic             ex_rdEn,
  input  logic             ex_DMread,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd_ad,
  input  logic             mem_rdEn,
  input  logic [4:0]       wb_rd_ad,
  input  logic             wb_rdEn,
  input  logic             mem_dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_timeout
);

  localparam int unsigned WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state, state_next;
  logic [WC_W-1:0] wait_cnt, wait_next;
  ctrl_t           run_ctrl, ctrl;
  logic            load_use;
  logic [1:0]      fwd_a_raw, fwd_b_raw;

  pip_fwd_unit u_fwd_a (
    .src_ad    (ex_rs1_ad),
    .mem_rd_ad (mem_rd_ad),
    .mem_rdEn  (mem_rdEn),
    .wb_rd_ad  (wb_rd_ad),
    .wb_rdEn   (wb_rdEn),
    .fwd_sel   (fwd_a_raw)
  );

  pip_fwd_unit u_fwd_b (
    .src_ad    (ex_rs2_ad),
    .mem_rd_ad (mem_rd_ad),
    .mem_rdEn  (mem_rdEn),
    .wb_rd_ad  (wb_rd_ad),
    .wb_rdEn   (wb_rdEn),
    .fwd_sel   (fwd_b_raw)
  );

  // Controls when memory is not holding the pipe: branch beats load-use.
  always_comb begin
    load_use = ex_DMread && ex_rdEn && (ex_rd_ad != ZERO_REG) &&
               ((ex_rd_ad == id_rs1_ad) || (ex_rd_ad == id_rs2_ad));
    run_ctrl = CTRL_NORMAL;
    if (ex_branch_taken)
      run_ctrl = CTRL_BRANCH;
    else if (load_use)
      run_ctrl = CTRL_LOAD_USE;
  end

  // Next-state and Mealy control outputs; everything held low during reset.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    ctrl       = CTRL_ERROR;
    unique case (state)
      RUN: begin
        if (mem_dmem_req && !dmem_ready) begin
          ctrl       = CTRL_FREEZE;
          state_next = MEM_WAIT;
          wait_next  = WC_W'(1);
        end else begin
          ctrl = run_ctrl;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ctrl       = run_ctrl;
          state_next = RUN;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == WAIT_LAST)
            state_next = ERROR;
          else
            wait_next = wait_cnt + WC_W'(1);
        end
      end
      ERROR: begin
        ctrl = CTRL_ERROR;
      end
      default: begin
        ctrl       = CTRL_ERROR;
        state_next = RUN;
      end
    endcase
    if (!rst_n)
      ctrl = '0;
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_ex_en      = ctrl.id_ex_en;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign fwd_a         = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b         = rst_n ? fwd_b_raw : FWD_RF;
  assign err_timeout   = (state == ERROR);

  // State and wait-cycle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (!pc_en && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Self-checking bench for pip_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pip_hazard_ctrl;

  localparam int TO     = 4;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1_ad, id_rs2_ad, ex_rs1_ad, ex_rs2_ad, ex_rd_ad, mem_rd_ad, wb_rd_ad;
  logic ex_rdEn, ex_DMread, ex_branch_taken, mem_rdEn, wb_rdEn, mem_dmem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles;
  logic err_timeout;

  always #5 clk = ~clk;

  pip_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_ad(id_rs1_ad), .id_rs2_ad(id_rs2_ad),
    .ex_rs1_ad(ex_rs1_ad), .ex_rs2_ad(ex_rs2_ad), .ex_rd_ad(ex_rd_ad),
    .ex_rdEn(ex_rdEn), .ex_DMread(ex_DMread), .ex_branch_taken(ex_branch_taken),
    .mem_rd_ad(mem_rd_ad), .mem_rdEn(mem_rdEn), .wb_rd_ad(wb_rd_ad), .wb_rdEn(wb_rdEn),
    .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_rdEn, ex_DMread, br, mem_rdEn, wb_rdEn, req, rdy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [7:0] ctrl;
    logic [1:0] fa, fb;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive not-ready count, error flag, stall count.
  int m_nr  = 0;
  bit m_err = 1'b0;
  int m_cnt = 0;

  // Values sampled in the most recent step.
  logic [7:0] s_ctrl;
  logic [1:0] s_fa, s_fb;
  logic [CW-1:0] s_cnt;
  logic s_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.id_rs1 = 0; s.id_rs2 = 0; s.ex_rs1 = 0; s.ex_rs2 = 0; s.ex_rd = 0;
    s.mem_rd = 0; s.wb_rd = 0; s.ex_rdEn = 0; s.ex_DMread = 0; s.br = 0;
    s.mem_rdEn = 0; s.wb_rdEn = 0; s.req = 0; s.rdy = 0;
    return s;
  endfunction

  function automatic stim_t load_use5();
    stim_t s = idle();
    s.ex_rd = 5; s.ex_rdEn = 1; s.ex_DMread = 1; s.id_rs1 = 5; s.id_rs2 = 1;
    return s;
  endfunction

  function automatic stim_t mem_req(input logic rdy);
    stim_t s = idle();
    s.req = 1; s.rdy = rdy;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_rs1_ad = s.id_rs1; id_rs2_ad = s.id_rs2; ex_rs1_ad = s.ex_rs1; ex_rs2_ad = s.ex_rs2;
    ex_rd_ad = s.ex_rd; mem_rd_ad = s.mem_rd; wb_rd_ad = s.wb_rd;
    ex_rdEn = s.ex_rdEn; ex_DMread = s.ex_DMread; ex_branch_taken = s.br;
    mem_rdEn = s.mem_rdEn; wb_rdEn = s.wb_rdEn; mem_dmem_req = s.req; dmem_ready = s.rdy;
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src, input stim_t s);
    if (s.mem_rdEn && s.mem_rd != 0 && s.mem_rd == src) return 2'b10;
    if (s.wb_rdEn && s.wb_rd != 0 && s.wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_freeze(input stim_t s);
    return !m_err && !s.rdy && (m_nr > 0 || s.req);
  endfunction

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush, bubble}
  function automatic logic [7:0] m_ctrl(input stim_t s);
    bit lu;
    lu = s.ex_DMread && s.ex_rdEn && s.ex_rd != 0 && (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
    if (m_err)        return 8'b0000_0001;
    if (m_freeze(s))  return 8'b0000_1001;
    if (s.br)         return 8'b1111_1110;
    if (lu)           return 8'b0011_1010;
    return 8'b1111_1000;
  endfunction

  function automatic logic [7:0] dut_ctrl();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble};
  endfunction

  // One cycle: drive at negedge, check against model, advance model over posedge.
  task automatic step(input stim_t s);
    logic [7:0] e;
    bit fz;
    apply(s);
    #1;
    e  = m_ctrl(s);
    fz = m_freeze(s);
    s_ctrl = dut_ctrl(); s_fa = fwd_a; s_fb = fwd_b; s_cnt = stall_cycles; s_err = err_timeout;
    chk("ctrl", 32'(s_ctrl), 32'(e));
    chk("fwd_a", 32'(s_fa), 32'(m_fwd(s.ex_rs1, s)));
    chk("fwd_b", 32'(s_fb), 32'(m_fwd(s.ex_rs2, s)));
    chk("stall_cycles", 32'(s_cnt), 32'(m_cnt));
    chk("err_timeout", 32'(s_err), 32'(m_err));
    @(posedge clk);
    if (!e[7] && m_cnt < CNTMAX) m_cnt++;
    if (!m_err) begin
      if (fz) begin
        m_nr++;
        if (m_nr == TO) m_err = 1'b1;
      end else begin
        m_nr = 0;
      end
    end
    @(negedge clk);
  endtask

  // Reset pulse with hazardous inputs applied: all controls must stay low.
  task automatic do_reset();
    stim_t s = load_use5();
    s.req = 1; s.rdy = 0; s.mem_rd = 5; s.mem_rdEn = 1; s.ex_rs1 = 5; s.ex_rs2 = 5;
    apply(s);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", 32'(dut_ctrl()), 32'd0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_ctrl_edge", 32'(dut_ctrl()), 32'd0);
    chk("rst_cnt_edge", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    apply(idle());
    rst_n = 1'b1;
    m_nr = 0; m_err = 1'b0; m_cnt = 0;
  endtask

  vec_t vt[$];

  task automatic add_vec(input stim_t s, input logic [7:0] c, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.s = s; v.ctrl = c; v.fa = fa; v.fb = fb;
    vt.push_back(v);
  endtask

  initial begin
    stim_t s;
    int err_run;

    apply(idle());
    @(negedge clk);
    do_reset();

    // Single-cycle vectors evaluated in RUN.
    add_vec(idle(), 8'b1111_1000, 2'b00, 2'b00);
    add_vec(load_use5(), 8'b0011_1010, 2'b00, 2'b00);
    s = load_use5(); s.id_rs1 = 2; s.id_rs2 = 5;
    add_vec(s, 8'b0011_1010, 2'b00, 2'b00);
    s = load_use5(); s.ex_rd = 0; s.id_rs1 = 0;
    add_vec(s, 8'b1111_1000, 2'b00, 2'b00);
    s = load_use5(); s.ex_DMread = 0;
    add_vec(s, 8'b1111_1000, 2'b00, 2'b00);
    s = load_use5(); s.ex_rdEn = 0;
    add_vec(s, 8'b1111_1000, 2'b00, 2'b00);
    s = load_use5(); s.br = 1;
    add_vec(s, 8'b1111_1110, 2'b00, 2'b00);
    s = idle(); s.br = 1;
    add_vec(s, 8'b1111_1110, 2'b00, 2'b00);
    add_vec(mem_req(1'b1), 8'b1111_1000, 2'b00, 2'b00);
    s = idle(); s.mem_rd = 7; s.wb_rd = 7; s.ex_rs1 = 7; s.ex_rs2 = 3; s.mem_rdEn = 1; s.wb_rdEn = 1;
    add_vec(s, 8'b1111_1000, 2'b10, 2'b00);
    s.mem_rdEn = 0;
    add_vec(s, 8'b1111_1000, 2'b01, 2'b00);
    s = idle(); s.mem_rdEn = 1; s.wb_rdEn = 1;
    add_vec(s, 8'b1111_1000, 2'b00, 2'b00);
    s = idle(); s.mem_rd = 9; s.wb_rd = 9; s.ex_rs1 = 9; s.ex_rs2 = 9; s.mem_rdEn = 1; s.wb_rdEn = 1;
    add_vec(s, 8'b1111_1000, 2'b10, 2'b10);
    s = idle(); s.mem_rd = 4; s.wb_rd = 4; s.ex_rs2 = 4; s.wb_rdEn = 1;
    add_vec(s, 8'b1111_1000, 2'b00, 2'b01);

    foreach (vt[i]) begin
      step(vt[i].s);
      chk($sformatf("vec%0d_ctrl", i), 32'(s_ctrl), 32'(vt[i].ctrl));
      chk($sformatf("vec%0d_fwd", i), 32'({s_fa, s_fb}), 32'({vt[i].fa, vt[i].fb}));
    end

    // Load-use stalls exactly one cycle.
    do_reset();
    step(load_use5());
    chk("lu_ctrl", 32'(s_ctrl), 32'(8'b0011_1010));
    step(idle());
    chk("lu_release", 32'(s_ctrl), 32'(8'b1111_1000));
    chk("lu_cnt", 32'(s_cnt), 32'd1);

    // Branch squashes a simultaneous load-use without stalling.
    do_reset();
    s = load_use5(); s.br = 1;
    step(s);
    chk("br_lu_ctrl", 32'(s_ctrl), 32'(8'b1111_1110));
    step(idle());
    chk("br_lu_cnt", 32'(s_cnt), 32'd0);

    // Three not-ready cycles then ready: three frozen cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(mem_req(1'b0));
      chk($sformatf("wait%0d_ctrl", i), 32'(s_ctrl), 32'(8'b0000_1001));
    end
    step(mem_req(1'b1));
    chk("wait_release", 32'(s_ctrl), 32'(8'b1111_1000));
    step(idle());
    chk("wait_cnt", 32'(s_cnt), 32'd3);
    chk("wait_ctrl_after", 32'(s_ctrl), 32'(8'b1111_1000));

    // Timeout to ERROR, stickiness, counter saturation, reset recovery.
    do_reset();
    for (int i = 0; i < TO; i++) begin
      step(mem_req(1'b0));
      chk($sformatf("to%0d_err", i), 32'(s_err), 32'd0);
    end
    step(idle());
    chk("to_err", 32'(s_err), 32'd1);
    chk("to_ctrl", 32'(s_ctrl), 32'(8'b0000_0001));
    step(mem_req(1'b1));
    chk("to_sticky", 32'(s_err), 32'd1);
    for (int i = 0; i < 16; i++) step(idle());
    chk("sat_cnt", 32'(s_cnt), 32'(CNTMAX));
    do_reset();
    step(idle());
    chk("to_clear_err", 32'(s_err), 32'd0);
    chk("to_clear_ctrl", 32'(s_ctrl), 32'(8'b1111_1000));
    chk("to_clear_cnt", 32'(s_cnt), 32'd0);

    // Randomized traffic against the reference model.
    err_run = 0;
    for (int n = 0; n < 1500; n++) begin
      if ((m_err && err_run > 3) || $urandom_range(0, 79) == 0) begin
        do_reset();
        err_run = 0;
      end
      s.id_rs1 = 5'($urandom_range(0, 3)); s.id_rs2 = 5'($urandom_range(0, 3));
      s.ex_rs1 = 5'($urandom_range(0, 3)); s.ex_rs2 = 5'($urandom_range(0, 3));
      s.ex_rd  = 5'($urandom_range(0, 3)); s.mem_rd = 5'($urandom_range(0, 3));
      s.wb_rd  = 5'($urandom_range(0, 3));
      s.ex_rdEn = 1'($urandom); s.ex_DMread = 1'($urandom); s.br = ($urandom_range(0, 4) == 0);
      s.mem_rdEn = 1'($urandom); s.wb_rdEn = 1'($urandom);
      s.req = ($urandom_range(0, 2) == 0); s.rdy = ($urandom_range(0, 2) != 0);
      step(s);
      if (m_err) err_run++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
